// File: rtl/gate_tt_checker.sv
// Truth-table exerciser for small combinational gates: sweeps every input vector,
// samples the gate after a settle interval and scores it against AND/OR/XOR/NAND.
module gate_tt_checker #(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          op_sel,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                mismatch,
  output logic [ERR_W-1:0]    err_count,
  output logic [N_INPUTS-1:0] first_err_vec,
  output logic                first_err_vld
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] OpAnd  = 2'd0;
  localparam logic [1:0] OpOr   = 2'd1;
  localparam logic [1:0] OpXor  = 2'd2;
  localparam logic [1:0] OpNand = 2'd3;

  localparam logic [N_INPUTS-1:0] LastVec = '1;
  localparam logic [CNT_W-1:0]    CntLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0]    ErrMax  = '1;

  logic [1:0]          state_q, state_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [N_INPUTS-1:0] ferr_vec_q, ferr_vec_d;
  logic                ferr_vld_q, ferr_vld_d;
  logic                mismatch_q, mismatch_d;

  logic exp_bit;
  logic sample_fail;

  // Reference function uses the op latched at start, never the live op_sel.
  always_comb begin
    exp_bit = 1'b0;
    unique case (op_q)
      OpAnd:   exp_bit = &stim_q;
      OpOr:    exp_bit = |stim_q;
      OpXor:   exp_bit = ^stim_q;
      OpNand:  exp_bit = ~&stim_q;
      default: exp_bit = 1'b0;
    endcase
  end

  assign sample_fail = (dut_out != exp_bit);

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = err_q;
    ferr_vec_d = ferr_vec_q;
    ferr_vld_d = ferr_vld_q;
    mismatch_d = 1'b0;

    if (abort) begin
      // Error history survives an abort so it can still be inspected.
      state_d = StIdle;
      stim_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = StSettle;
            stim_d     = '0;
            cnt_d      = '0;
            err_d      = '0;
            ferr_vld_d = 1'b0;
            op_d       = op_sel;
          end
        end
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_d = StSample;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StSample: begin
          if (sample_fail) begin
            mismatch_d = 1'b1;
            if (err_q != ErrMax) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!ferr_vld_q) begin
              ferr_vec_d = stim_q;
              ferr_vld_d = 1'b1;
            end
          end
          if (stim_q == LastVec) begin
            state_d = StDone;
          end else begin
            stim_d  = stim_q + N_INPUTS'(1);
            cnt_d   = '0;
            state_d = StSettle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stim_q     <= '0;
      cnt_q      <= '0;
      op_q       <= OpAnd;
      err_q      <= '0;
      ferr_vec_q <= '0;
      ferr_vld_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      err_q      <= err_d;
      ferr_vec_q <= ferr_vec_d;
      ferr_vld_q <= ferr_vld_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = (state_q == StSettle) || (state_q == StSample);
  assign done          = (state_q == StDone);
  assign pass          = (state_q == StDone) && (err_q == '0);
  assign mismatch      = mismatch_q;
  assign err_count     = err_q;
  assign first_err_vec = ferr_vec_q;
  assign first_err_vld = ferr_vld_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: a default 2-input instance and a 3-input,
// 2-bit-error-counter instance, each wired to a modelled gate under test.
module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [1:0] op_sel;
  logic       dut_out;
  logic [1:0] stim;
  logic       busy, done, pass, mismatch;
  logic [7:0] err_count;
  logic [1:0] first_err_vec;
  logic       first_err_vld;
  // 0 ideal AND, 1 stuck-at-0, 2 OR gate
  logic [1:0] mode;

  logic       start3, abort3;
  logic [1:0] op_sel3;
  logic       dut_out3;
  logic [2:0] stim3;
  logic       busy3, done3, pass3, mismatch3;
  logic [1:0] err_count3;
  logic [2:0] first_err_vec3;
  logic       first_err_vld3;

  int n_checks = 0;
  int n_fail   = 0;
  int edges, pulses;
  bit stim_ok;

  always #5 clk = ~clk;

  assign dut_out  = (mode == 2'd0) ? &stim : (mode == 2'd1) ? 1'b0 : |stim;
  assign dut_out3 = ~^stim3;

  gate_tt_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_sel(op_sel),
    .dut_out(dut_out), .stim(stim), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_vld(first_err_vld)
  );

  gate_tt_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2), .ERR_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .op_sel(op_sel3),
    .dut_out(dut_out3), .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch(mismatch3), .err_count(err_count3), .first_err_vec(first_err_vec3),
    .first_err_vld(first_err_vld3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a sweep on the 2-input instance; returns edges-to-done and mismatch pulse count.
  // For the defaults stim after edge k (k<12) must be k/3.
  task automatic run_sweep(input logic [1:0] op, output int e, output int p, output bit ok);
    e = 0; p = 0; ok = 1'b1;
    op_sel = op;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    if (stim !== 2'd0 || busy !== 1'b1) ok = 1'b0;
    while (!done && e < 100) begin
      tick();
      e++;
      if (mismatch) p++;
      if (!done && stim !== 2'(e / 3)) ok = 1'b0;
    end
  endtask

  task automatic run_sweep3(input logic [1:0] op, output int e, output int p);
    e = 0; p = 0;
    op_sel3 = op;
    start3  = 1'b1;
    tick();
    start3  = 1'b0;
    while (!done3 && e < 200) begin
      tick();
      e++;
      if (mismatch3) p++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_sel = 2'd0; mode = 2'd0;
    start3 = 1'b0; abort3 = 1'b0; op_sel3 = 2'd0;
    #12;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy_done_pass", {busy, done, pass}, 32'd0);
    check("rst_err", {err_count, first_err_vld, mismatch}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: ideal AND, op changed mid-sweep must not matter
    mode = 2'd0;
    op_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    op_sel = 2'd3;
    edges = 0; pulses = 0;
    while (!done && edges < 100) begin
      tick(); edges++;
      if (mismatch) pulses++;
    end
    check("t1_latency", 32'(edges), 32'd12);
    check("t1_pass", {done, pass}, 32'b11);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_pulses", 32'(pulses), 32'd0);
    check("t1_stim_hold", 32'(stim), 32'd3);
    run_sweep(2'd0, edges, pulses, stim_ok);
    check("t1_stim_seq", 32'(stim_ok), 32'd1);

    // 2: stuck-at-0
    mode = 2'd1;
    run_sweep(2'd0, edges, pulses, stim_ok);
    check("t2_latency", 32'(edges), 32'd12);
    check("t2_pulse_at_done", 32'(mismatch), 32'd1);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_err", 32'(err_count), 32'd1);
    check("t2_first", {first_err_vld, first_err_vec}, {1'b1, 2'd3});
    check("t2_pass", {done, pass}, 32'b10);
    tick();
    check("t2_pulse_one_cycle", 32'(mismatch), 32'd0);

    // 3: OR gate scored as AND; then abort from DONE keeps error history
    mode = 2'd2;
    run_sweep(2'd0, edges, pulses, stim_ok);
    check("t3_pulses", 32'(pulses), 32'd2);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_first", {first_err_vld, first_err_vec}, {1'b1, 2'd1});
    check("t3_pass", 32'(pass), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t3_abort_done", {busy, done, pass}, 32'd0);
    check("t3_abort_hold", {err_count, first_err_vld, first_err_vec}, {8'd2, 1'b1, 2'd1});

    // 4: 3-input inverted XOR, saturating 2-bit counter
    run_sweep3(2'd2, edges, pulses);
    check("t4_latency", 32'(edges), 32'd24);
    check("t4_pulses", 32'(pulses), 32'd8);
    check("t4_err_sat", 32'(err_count3), 32'd3);
    check("t4_first", {first_err_vld3, first_err_vec3}, {1'b1, 3'd0});
    check("t4_pass", {done3, pass3}, 32'b10);

    // 5: async reset during SETTLE of vector 2
    mode = 2'd0;
    op_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("t5_pre", {busy, stim}, {1'b1, 2'd2});
    rst_n = 1'b0;
    #1;
    check("t5_rst_stim_busy", {busy, done, pass, stim}, 32'd0);
    check("t5_rst_err", {err_count, first_err_vld, mismatch}, 32'd0);
    tick();
    rst_n = 1'b1;
    check("t5_idle", 32'(busy), 32'd0);
    run_sweep(2'd0, edges, pulses, stim_ok);
    check("t5_rerun", {32'(edges), 31'd0, stim_ok}, {32'd12, 32'd1});
    check("t5_rerun_pass", {done, pass}, 32'b11);

    // 6: start while busy ignored, abort mid-sweep, start+abort in DONE
    start = 1'b1; tick();
    repeat (4) tick();
    start = 1'b0;
    check("t6_start_ignored", {busy, stim}, {1'b1, 2'd1});
    abort = 1'b1; tick(); abort = 1'b0;
    check("t6_abort", {busy, done, stim}, 32'd0);
    tick();
    check("t6_stay_idle", 32'(busy), 32'd0);
    run_sweep(2'd0, edges, pulses, stim_ok);
    check("t6_done", 32'(done), 32'd1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("t6_both_idle", {busy, done}, 32'd0);
    tick();
    check("t6_both_stay", {busy, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
